// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

    typedef enum logic [2:0] {
        S_ISSUE0 = 3'd0,
        S_ISSUE1 = 3'd1,
        S_ISSUE2 = 3'd2,
        S_ISSUE3 = 3'd3,
        S_LAST   = 3'd4,
        S_HOLD   = 3'd5
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] BUBBLE     = 32'h0;

    function automatic logic is_issue(input fetch_state_e s);
        return (s == S_ISSUE0) || (s == S_ISSUE1) || (s == S_ISSUE2) || (s == S_ISSUE3);
    endfunction

    // Issue states are encoded so their low two bits are the byte offset.
    function automatic logic [31:0] issue_offset(input fetch_state_e s);
        logic [2:0] v;
        v = s;
        return {30'd0, v[1:0]};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from a byte-wide memory
// port and presents them to decode, with redirect and stall handling.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jmp_en,
    input  logic [31:0] jmp_pc,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_din,
    output logic        mem_re,
    output logic [31:0] mem_a,
    output logic [31:0] is,
    output logic [31:0] pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [23:0]  buf_q, buf_d;
    logic [31:0]  is_d, pc_d;
    logic         acc_q;

    // Reset and redirect both suppress the request combinationally.
    assign mem_re = rst_n & ~jmp_en & is_issue(state_q);
    assign mem_a  = mem_re ? fpc_q + issue_offset(state_q) : 32'h0;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        buf_d   = buf_q;
        is_d    = is;
        pc_d    = pc;
        if (jmp_en) begin
            fpc_d   = jmp_pc;
            is_d    = BUBBLE;
            pc_d    = 32'h0;
            state_d = S_ISSUE0;
        end else begin
            unique case (state_q)
                S_ISSUE0: begin
                    if (mem_rdy) state_d = S_ISSUE1;
                end
                S_ISSUE1: begin
                    if (acc_q) buf_d[7:0] = mem_din;
                    if (mem_rdy) state_d = S_ISSUE2;
                end
                S_ISSUE2: begin
                    if (acc_q) buf_d[15:8] = mem_din;
                    if (mem_rdy) state_d = S_ISSUE3;
                end
                S_ISSUE3: begin
                    if (acc_q) buf_d[23:16] = mem_din;
                    if (mem_rdy) state_d = S_LAST;
                end
                S_LAST: begin
                    is_d    = {mem_din, buf_q};
                    pc_d    = fpc_q + 32'(INST_BYTES);
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (!stall) begin
                        fpc_d   = fpc_q + 32'(INST_BYTES);
                        is_d    = BUBBLE;
                        state_d = S_ISSUE0;
                    end
                end
                default: state_d = S_ISSUE0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ISSUE0;
            fpc_q   <= RESET_PC;
            buf_q   <= 24'h0;
            is      <= BUBBLE;
            pc      <= 32'h0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            buf_q   <= buf_d;
            is      <= is_d;
            pc      <= pc_d;
            acc_q   <= mem_re & mem_rdy;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch against a transaction-level fetch model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_pc = 32'h0;
    logic        mem_rdy = 1'b0;
    logic [7:0]  mem_din = 8'h0;
    logic        mem_re;
    logic [31:0] mem_a;
    logic [31:0] is;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current fetch address, bytes granted so far, presenting flag.
    logic [31:0] m_f;
    logic [31:0] m_is;
    logic [31:0] m_pc;
    int          m_got;
    bit          m_present;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .jmp_en  (jmp_en),
        .jmp_pc  (jmp_pc),
        .mem_rdy (mem_rdy),
        .mem_din (mem_din),
        .mem_re  (mem_re),
        .mem_a   (mem_a),
        .is      (is),
        .pc      (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h00;
            32'h2: return 8'h50;
            32'h3: return 8'h00;
            32'h4: return 8'h93;
            32'h5: return 8'h00;
            32'h6: return 8'h10;
            32'h7: return 8'h00;
            32'hFFFFFFFE: return 8'hAB;
            32'hFFFFFFFF: return 8'hCD;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory returns data one cycle after a granted request; garbage otherwise.
    always @(posedge clk) begin
        if (mem_re && mem_rdy) mem_din <= mem_byte(mem_a);
        else mem_din <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_f = 32'h0;
        m_is = 32'h0;
        m_pc = 32'h0;
        m_got = 0;
        m_present = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input bit rdy, input bit stl, input bit jmp, input logic [31:0] jpc);
        bit          exp_re;
        logic [31:0] exp_a;
        @(negedge clk);
        mem_rdy = rdy;
        stall = stl;
        jmp_en = jmp;
        jmp_pc = jpc;
        #2;
        exp_re = !jmp && !m_present && (m_got < 4);
        exp_a = exp_re ? m_f + 32'(m_got) : 32'h0;
        chk("mem_re", {31'd0, mem_re}, {31'd0, exp_re});
        chk("mem_a", mem_a, exp_a);
        chk("is", is, m_is);
        chk("pc", pc, m_pc);
        if (jmp) begin
            m_f = jpc;
            m_got = 0;
            m_present = 0;
            m_is = 32'h0;
            m_pc = 32'h0;
        end else if (m_present) begin
            if (!stl) begin
                m_f = m_f + 32'd4;
                m_got = 0;
                m_present = 0;
                m_is = 32'h0;
            end
        end else if (m_got == 4) begin
            m_is = word_at(m_f);
            m_pc = m_f + 32'd4;
            m_present = 1;
        end else if (rdy) begin
            m_got++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        logic [31:0] jpc;
        for (int i = 0; i < cycles; i++) begin
            case ($urandom_range(0, 2))
                0: jpc = $urandom;
                1: jpc = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
                default: jpc = 32'($urandom_range(0, 64));
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 3, jpc);
        end
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset mem_re", {31'd0, mem_re}, 32'd0);
        chk("reset mem_a", mem_a, 32'h0);
        chk("reset is", is, 32'h0);
        chk("reset pc", pc, 32'h0);
        release_reset();

        // Nominal fetch from address 0.
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 32'h0);
            chk("nominal mem_a", mem_a, 32'(k));
        end
        step(1, 0, 0, 32'h0);
        chk("last mem_re", {31'd0, mem_re}, 32'd0);
        step(1, 0, 0, 32'h0);
        chk("first is", is, 32'h00500013);
        chk("first pc", pc, 32'h4);
        step(1, 0, 0, 32'h0);
        chk("next mem_a", mem_a, 32'h4);

        // Two wait cycles on the third byte.
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("wait mem_a 0", mem_a, 32'h6);
        step(0, 0, 0, 32'h0);
        chk("wait mem_a 1", mem_a, 32'h6);
        step(1, 0, 0, 32'h0);
        chk("wait mem_a 2", mem_a, 32'h6);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);

        // Stall for three cycles when the word appears.
        for (int i = 0; i < 4; i++) begin
            step(1, i < 3, 0, 32'h0);
            chk("stall is", is, 32'h00100093);
            chk("stall pc", pc, 32'h8);
            chk("stall mem_re", {31'd0, mem_re}, 32'd0);
        end
        step(1, 0, 0, 32'h0);
        chk("post stall mem_a", mem_a, 32'h8);

        // Redirect during the third issue.
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h100);
        chk("jmp mem_re", {31'd0, mem_re}, 32'd0);
        step(1, 0, 0, 32'h0);
        chk("jmp is", is, 32'h0);
        chk("jmp mem_a", mem_a, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0);

        // Redirect wins over stall while holding; target wraps past 2^32.
        step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'hFFFFFFFE);
        step(1, 0, 0, 32'h0);
        chk("jmp hold is", is, 32'h0);
        chk("wrap mem_a 0", mem_a, 32'hFFFFFFFE);
        step(1, 0, 0, 32'h0);
        chk("wrap mem_a 1", mem_a, 32'hFFFFFFFF);
        step(1, 0, 0, 32'h0);
        chk("wrap mem_a 2", mem_a, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("wrap mem_a 3", mem_a, 32'h1);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("wrap is", is, 32'h0013CDAB);
        chk("wrap pc", pc, 32'h2);

        random_phase(3000);

        // Asynchronous reset in the middle of a fetch.
        step(1, 0, 1, 32'h40);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async mem_re", {31'd0, mem_re}, 32'd0);
        chk("async mem_a", mem_a, 32'h0);
        chk("async is", is, 32'h0);
        chk("async pc", pc, 32'h0);
        model_reset();
        release_reset();
        step(1, 0, 0, 32'h0);
        chk("restart mem_a", mem_a, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0);
        chk("restart is", is, 32'h00500013);

        random_phase(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
